// File: rtl/alu_register_stage.sv
// alu_register_stage: registered accumulator behind the 4-bit ALU.
// Feeds ALUout[3:0] back as operand B and adds a 4-step shift-add multiply.
module alu_register_stage (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Data,
    input  logic [2:0] Function,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] ALUout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0] state;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic [7:0] acc;
    logic [1:0] step;

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] op_res;
    logic [7:0] partial;
    logic [7:0] acc_next;

    // Single-cycle result for the op selected at an accepting edge
    always_comb begin
        op_a   = Data;
        op_b   = ALUout[3:0];
        op_res = ALUout;
        case (Function)
            3'b000: op_res = {4'b0, op_a} + {4'b0, op_b};
            3'b010: op_res = {7'b0, (|op_a) | (|op_b)};
            3'b011: op_res = {7'b0, (&op_a) & (&op_b)};
            3'b100: op_res = {op_a, op_b};
            3'b101: op_res = {4'b0, op_b} << op_a[2:0];
            3'b111: op_res = 8'h00;
            default: op_res = ALUout;
        endcase
    end

    // Next accumulator value for the current multiply step
    always_comb begin
        partial  = {4'b0, mcand} << step;
        acc_next = acc + (mplier[0] ? partial : 8'h00);
    end

    // IDLE/MUL sequencer, result register and handshake flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= S_IDLE;
            mcand  <= 4'h0;
            mplier <= 4'h0;
            acc    <= 8'h00;
            step   <= 2'd0;
            ALUout <= 8'h00;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Function == 3'b001) begin
                            mcand  <= Data;
                            mplier <= ALUout[3:0];
                            acc    <= 8'h00;
                            step   <= 2'd0;
                            Busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            ALUout <= op_res;
                            Done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    step   <= step + 2'd1;
                    if (step == 2'd3) begin
                        ALUout <= acc_next;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_register_stage.sv
// tb_alu_register_stage: directed and random checks of alu_register_stage
// against an arithmetic reference model.
module tb_alu_register_stage;

    logic       Clock;
    logic       Reset;
    logic [3:0] Data;
    logic [2:0] Function;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic [7:0] ALUout;

    int n_checks = 0;
    int n_fail   = 0;

    int m_q;
    int m_left;
    int m_a;
    int m_b;
    bit m_done;

    alu_register_stage dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Data     (Data),
        .Function (Function),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .ALUout   (ALUout)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic int ref_alu(input int fn, input int a, input int b,
                                   input int cur);
        case (fn)
            0: return a + b;
            2: return (a != 0 || b != 0) ? 1 : 0;
            3: return (a == 15 && b == 15) ? 1 : 0;
            4: return a * 16 + b;
            5: return (b * (1 << (a % 8))) % 256;
            6: return cur;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_q    = 0;
        m_left = 0;
        m_a    = 0;
        m_b    = 0;
        m_done = 1'b0;
    endtask

    // advance one clock edge; model follows the inputs seen at that edge
    task automatic tick();
        @(posedge Clock);
        if (Reset) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_q    = (m_a * m_b) % 256;
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
            end
        end else if (Start) begin
            if (Function == 3'd1) begin
                m_a    = int'(Data);
                m_b    = m_q % 16;
                m_left = 4;
                m_done = 1'b0;
            end else begin
                m_q    = ref_alu(int'(Function), int'(Data), m_q % 16, m_q);
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
        #1;
    endtask

    task automatic op(input logic [3:0] d, input logic [2:0] f);
        Start    = 1'b1;
        Data     = d;
        Function = f;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Data = 4'h0;
        Function = 3'd0;
        model_reset();
        #1;
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_init: got %b %b %h want 0 0 00", Busy, Done, ALUout);
        end
        tick();
        tick();
        Reset = 1'b0;
        op(4'h5, 3'd0);
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'h05}) begin
            n_fail++;
            $display("FAIL reset_preload: got %b %b %h want 0 1 05", Busy, Done, ALUout);
        end
        #3 Reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_async: got %b %b %h want 0 0 00", Busy, Done, ALUout);
        end
        #1 Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got %b %b %h want 0 0 00", i, Busy, Done, ALUout);
            end
        end
    endtask

    task automatic test_add_chain();
        op(4'h0, 3'd7);
        n_checks++;
        if ({Done, ALUout} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL add_clear: got %b %h want 1 00", Done, ALUout);
        end
        Start = 1'b1;
        Data = 4'hA;
        Function = 3'd0;
        tick();
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'h0A}) begin
            n_fail++;
            $display("FAIL add_0a: got %b %b %h want 0 1 0a", Busy, Done, ALUout);
        end
        Data = 4'h9;
        tick();
        Start = 1'b0;
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'h13}) begin
            n_fail++;
            $display("FAIL add_carry: got %b %b %h want 0 1 13", Busy, Done, ALUout);
        end
        tick();
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b00, 8'h13}) begin
            n_fail++;
            $display("FAIL add_idle: got %b %b %h want 0 0 13", Busy, Done, ALUout);
        end
    endtask

    task automatic test_multiply();
        op(4'h0, 3'd7);
        op(4'hF, 3'd0);
        op(4'h0, 3'd4);
        n_checks++;
        if (ALUout !== 8'h0F) begin
            n_fail++;
            $display("FAIL mul_setup: got %h want 0f", ALUout);
        end
        op(4'hF, 3'd1);
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b10, 8'h0F}) begin
            n_fail++;
            $display("FAIL mul_start: got %b %b %h want 1 0 0f", Busy, Done, ALUout);
        end
        Start = 1'b1;
        Function = 3'd0;
        for (int i = 1; i < 4; i++) begin
            Data = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if ({Busy, Done, ALUout} !== {2'b10, 8'h0F}) begin
                n_fail++;
                $display("FAIL mul_busy%0d: got %b %b %h want 1 0 0f", i, Busy, Done, ALUout);
            end
        end
        Data = 4'($urandom_range(0, 15));
        tick();
        Start = 1'b0;
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'hE1}) begin
            n_fail++;
            $display("FAIL mul_result: got %b %b %h want 0 1 e1", Busy, Done, ALUout);
        end
        tick();
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b00, 8'hE1}) begin
            n_fail++;
            $display("FAIL mul_after: got %b %b %h want 0 0 e1", Busy, Done, ALUout);
        end
    endtask

    task automatic test_concat_shift();
        op(4'h0, 3'd7);
        op(4'hA, 3'd0);
        op(4'h9, 3'd0);
        op(4'h5, 3'd4);
        n_checks++;
        if (ALUout !== 8'h53) begin
            n_fail++;
            $display("FAIL concat_53: got %h want 53", ALUout);
        end
        op(4'h0, 3'd7);
        op(4'h3, 3'd0);
        op(4'h2, 3'd5);
        n_checks++;
        if (ALUout !== 8'h0C) begin
            n_fail++;
            $display("FAIL shift_0c: got %h want 0c", ALUout);
        end
        op(4'h7, 3'd5);
        n_checks++;
        if (ALUout !== 8'h00) begin
            n_fail++;
            $display("FAIL shift_trunc: got %h want 00", ALUout);
        end
        op(4'h3, 3'd0);
        op(4'h7, 3'd5);
        n_checks++;
        if (ALUout !== 8'h80) begin
            n_fail++;
            $display("FAIL shift_80: got %h want 80", ALUout);
        end
    endtask

    task automatic test_reductions();
        op(4'h0, 3'd7);
        op(4'h0, 3'd2);
        n_checks++;
        if (ALUout !== 8'h00) begin
            n_fail++;
            $display("FAIL or_zero: got %h want 00", ALUout);
        end
        op(4'h1, 3'd2);
        n_checks++;
        if (ALUout !== 8'h01) begin
            n_fail++;
            $display("FAIL or_one: got %h want 01", ALUout);
        end
        op(4'h0, 3'd7);
        op(4'hF, 3'd0);
        op(4'hF, 3'd3);
        n_checks++;
        if (ALUout !== 8'h01) begin
            n_fail++;
            $display("FAIL and_one: got %h want 01", ALUout);
        end
        op(4'hE, 3'd3);
        n_checks++;
        if (ALUout !== 8'h00) begin
            n_fail++;
            $display("FAIL and_zero: got %h want 00", ALUout);
        end
        op(4'h4, 3'd0);
        op(4'h9, 3'd6);
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'h04}) begin
            n_fail++;
            $display("FAIL hold: got %b %b %h want 0 1 04", Busy, Done, ALUout);
        end
    endtask

    task automatic test_reset_mid_mul();
        op(4'h0, 3'd7);
        op(4'hF, 3'd0);
        op(4'hF, 3'd1);
        tick();
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmul_busy: got %b want 1", Busy);
        end
        #3 Reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL rmul_async: got %b %b %h want 0 0 00", Busy, Done, ALUout);
        end
        #1 Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
                n_fail++;
                $display("FAIL rmul_quiet%0d: got %b %b %h want 0 0 00", i, Busy, Done, ALUout);
            end
        end
        op(4'h3, 3'd0);
        n_checks++;
        if ({Busy, Done, ALUout} !== {2'b01, 8'h03}) begin
            n_fail++;
            $display("FAIL rmul_recover: got %b %b %h want 0 1 03", Busy, Done, ALUout);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        for (int i = 0; i < 300; i++) begin
            Start    = ($urandom_range(0, 3) != 0);
            Data     = 4'($urandom_range(0, 15));
            Function = 3'($urandom_range(0, 7));
            tick();
            exp = {(m_left > 0), m_done, 8'(m_q)};
            n_checks++;
            if ({Busy, Done, ALUout} !== exp) begin
                n_fail++;
                $display("FAIL random%0d: got %b %b %h want %b %b %h",
                         i, Busy, Done, ALUout, exp[9], exp[8], exp[7:0]);
            end
            if ($urandom_range(0, 60) == 0) begin
                #3 Reset = 1'b1;
                model_reset();
                #1;
                n_checks++;
                if ({Busy, Done, ALUout} !== {2'b00, 8'h00}) begin
                    n_fail++;
                    $display("FAIL random_reset%0d: got %b %b %h want 0 0 00",
                             i, Busy, Done, ALUout);
                end
                #1 Reset = 1'b0;
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_chain();
        test_multiply();
        test_concat_shift();
        test_reductions();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
